// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// decode_stage
//
// RV32I decode stage feeding the execute-stage operand interface. Decodes the
// fetched instruction, reads two operands from an internal 32x32 register file
// (which also takes the write-back port) and registers operands, ALU op, PC
// and control into an ID/EX pipeline register with stall and flush.
//
// Optional feature macro: DECODE_WB_BYPASS_EN
//   defined   - register-file reads see a same-cycle write-back (write-through)
//   undefined - reads return the pre-write value; upstream hazard logic must
//               stall one cycle on a read-after-write-back collision
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   instr_i/pc_i   instruction from fetch and its PC, qualified by valid_i
//   stall_i        hold the ID/EX register
//   flush_i        insert a bubble (wins over stall_i)
//   wb_en_i/wb_rd_i/wb_data_i  register-file write-back port
//   a_o/b_o        ALU operands
//   alu_control_o  ALU operation code
//   pc_address_o   PC handed to execute
//   rd_o           destination register
//   reg_write_o/mem_read_o/mem_write_o  control
//   store_data_o   rs2 value for stores
//   valid_o        ID/EX entry valid
//   illegal_o      one-cycle pulse on an illegal opcode
//------------------------------------------------------------------------------
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [3:0]  alu_control_o,
  output logic [31:0] pc_address_o,
  output logic [4:0]  rd_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] store_data_o,
  output logic        valid_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_SLL    = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0011;
  localparam logic [3:0] ALU_SLTU   = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_AND    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  // Instruction fields
  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_sh_s;

  assign opcode_s = instr_i[6:0];
  assign rd_s     = instr_i[11:7];
  assign funct3_s = instr_i[14:12];
  assign rs1_s    = instr_i[19:15];
  assign rs2_s    = instr_i[24:20];
  assign imm_i_s  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u_s  = {instr_i[31:12], 12'h000};
  assign imm_sh_s = {27'd0, instr_i[24:20]};

  // Register file; entry 0 exists but is never written
  logic [31:0] rf_q [NREGS];
  logic        wb_we_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;

  assign wb_we_s = wb_en_i && (wb_rd_i != 5'd0);

  // Register-file write port; writes are independent of stall/flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= 32'h0000_0000;
      end
    end else if (wb_we_s) begin
      rf_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Register-file read ports, x0 hard-wired to zero
  always_comb begin
    rs1_val_s = 32'h0000_0000;
    rs2_val_s = 32'h0000_0000;
    if (rs1_s == 5'd0) begin
      rs1_val_s = 32'h0000_0000;
`ifdef DECODE_WB_BYPASS_EN
    end else if (wb_we_s && (wb_rd_i == rs1_s)) begin
      rs1_val_s = wb_data_i;
`endif
    end else begin
      rs1_val_s = rf_q[rs1_s];
    end
    if (rs2_s == 5'd0) begin
      rs2_val_s = 32'h0000_0000;
`ifdef DECODE_WB_BYPASS_EN
    end else if (wb_we_s && (wb_rd_i == rs2_s)) begin
      rs2_val_s = wb_data_i;
`endif
    end else begin
      rs2_val_s = rf_q[rs2_s];
    end
  end

  // Decoded values for the current instruction
  logic [31:0] dec_a_s;
  logic [31:0] dec_b_s;
  logic [3:0]  dec_alu_s;
  logic [4:0]  dec_rd_s;
  logic        dec_rw_s;
  logic        dec_mr_s;
  logic        dec_mw_s;
  logic        dec_illegal_s;

  // Opcode/funct decode into operands and control
  always_comb begin
    dec_a_s       = rs1_val_s;
    dec_b_s       = rs2_val_s;
    dec_alu_s     = ALU_ADD;
    dec_rd_s      = rd_s;
    dec_rw_s      = 1'b0;
    dec_mr_s      = 1'b0;
    dec_mw_s      = 1'b0;
    dec_illegal_s = 1'b0;
    case (opcode_s)
      OPC_R, OPC_I: begin
        dec_rw_s = 1'b1;
        if (opcode_s == OPC_I) begin
          // Shift-immediates take the zero-extended shamt field
          if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
            dec_b_s = imm_sh_s;
          end else begin
            dec_b_s = imm_i_s;
          end
        end else begin
          dec_b_s = rs2_val_s;
        end
        case (funct3_s)
          // instr[30] is funct7[5]; addi has no subtract form
          3'b000: begin
            if ((opcode_s == OPC_R) && instr_i[30]) begin
              dec_alu_s = ALU_SUB;
            end else begin
              dec_alu_s = ALU_ADD;
            end
          end
          3'b001: dec_alu_s = ALU_SLL;
          3'b010: dec_alu_s = ALU_SLT;
          3'b011: dec_alu_s = ALU_SLTU;
          3'b100: dec_alu_s = ALU_XOR;
          3'b101: begin
            if (instr_i[30]) begin
              dec_alu_s = ALU_SRA;
            end else begin
              dec_alu_s = ALU_SRL;
            end
          end
          3'b110: dec_alu_s = ALU_OR;
          3'b111: dec_alu_s = ALU_AND;
          default: dec_alu_s = ALU_ADD;
        endcase
      end
      OPC_LOAD: begin
        dec_b_s  = imm_i_s;
        dec_mr_s = 1'b1;
        dec_rw_s = 1'b1;
      end
      OPC_STORE: begin
        dec_b_s  = imm_s_s;
        dec_mw_s = 1'b1;
        dec_rd_s = 5'd0;
      end
      OPC_LUI: begin
        dec_a_s   = 32'h0000_0000;
        dec_b_s   = imm_u_s;
        dec_alu_s = ALU_PASS_B;
        dec_rw_s  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_a_s  = pc_i;
        dec_b_s  = imm_u_s;
        dec_rw_s = 1'b1;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // ID/EX pipeline register
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  alu_q, alu_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        mr_q, mr_d;
  logic        mw_q, mw_d;
  logic [31:0] sd_q, sd_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;

  // ID/EX next state: flush > stall > load; bubbles keep data, clear control
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    pc_d      = pc_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    mr_d      = mr_q;
    mw_d      = mw_q;
    sd_d      = sd_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (flush_i) begin
      valid_d   = 1'b0;
      rw_d      = 1'b0;
      mr_d      = 1'b0;
      mw_d      = 1'b0;
      illegal_d = 1'b0;
    end else if (stall_i) begin
      // Illegal is a pulse; a stall must not stretch it
      illegal_d = 1'b0;
    end else if (valid_i && dec_illegal_s) begin
      valid_d   = 1'b0;
      alu_d     = 4'b0000;
      rd_d      = 5'd0;
      rw_d      = 1'b0;
      mr_d      = 1'b0;
      mw_d      = 1'b0;
      pc_d      = pc_i;
      illegal_d = 1'b1;
    end else if (valid_i) begin
      a_d       = dec_a_s;
      b_d       = dec_b_s;
      alu_d     = dec_alu_s;
      pc_d      = pc_i;
      rd_d      = dec_rd_s;
      rw_d      = dec_rw_s;
      mr_d      = dec_mr_s;
      mw_d      = dec_mw_s;
      sd_d      = rs2_val_s;
      valid_d   = 1'b1;
      illegal_d = 1'b0;
    end else begin
      valid_d   = 1'b0;
      alu_d     = 4'b0000;
      rd_d      = 5'd0;
      rw_d      = 1'b0;
      mr_d      = 1'b0;
      mw_d      = 1'b0;
      illegal_d = 1'b0;
    end
  end

  // ID/EX state update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q       <= 32'h0000_0000;
      b_q       <= 32'h0000_0000;
      alu_q     <= 4'b0000;
      pc_q      <= RESET_PC;
      rd_q      <= 5'd0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      sd_q      <= 32'h0000_0000;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      pc_q      <= pc_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      mr_q      <= mr_d;
      mw_q      <= mw_d;
      sd_q      <= sd_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  assign a_o           = a_q;
  assign b_o           = b_q;
  assign alu_control_o = alu_q;
  assign pc_address_o  = pc_q;
  assign rd_o          = rd_q;
  assign reg_write_o   = rw_q;
  assign mem_read_o    = mr_q;
  assign mem_write_o   = mw_q;
  assign store_data_o  = sd_q;
  assign valid_o       = valid_q;
  assign illegal_o     = illegal_q;

endmodule
